// File: rtl/user_mgr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port between NumReq requesters,
// with in-order response routing through an ID FIFO of depth MaxTrans.
// Ports: clk_i/rst_i (async, active-high); per-requester req/addr/we/be/wdata
// in and gnt/rvalid out; broadcast rdata_o/err_o; shared mgr_* A-channel out
// and mgr_gnt/rvalid/rdata/err in; outstanding_o count; sticky unexp_rsp_o.
// Option: define USER_MGR_ARB_PRIO0_EN to give requester 0 fixed top priority.
module user_mgr_arbiter #(
    parameter int NumReq    = 2,
    parameter int MaxTrans  = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumReq-1:0]                    req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0]                    we_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
    output logic [NumReq-1:0]                    gnt_o,
    output logic [NumReq-1:0]                    rvalid_o,
    output logic [DataWidth-1:0]                 rdata_o,
    output logic                                 err_o,
    output logic                                 mgr_req_o,
    output logic [AddrWidth-1:0]                 mgr_addr_o,
    output logic                                 mgr_we_o,
    output logic [DataWidth/8-1:0]               mgr_be_o,
    output logic [DataWidth-1:0]                 mgr_wdata_o,
    input  logic                                 mgr_gnt_i,
    input  logic                                 mgr_rvalid_i,
    input  logic [DataWidth-1:0]                 mgr_rdata_i,
    input  logic                                 mgr_err_i,
    output logic [$clog2(MaxTrans+1)-1:0]        outstanding_o,
    output logic                                 unexp_rsp_o
);

    localparam int IdxW = $clog2(NumReq);
    localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int CntW = $clog2(MaxTrans + 1);

    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] rr_nxt;
    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;
    logic [IdxW-1:0] arb_idx;
    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] id_q [MaxTrans];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            unexp_q;
    logic            hs;
    logic            pop;

    // Ascending search from rr_q with wrap; first active request wins.
    always_comb begin
        int   cand;
        logic found;
        arb_idx = rr_q;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NumReq; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NumReq) cand = cand - NumReq;
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                arb_idx = IdxW'(cand);
            end
        end
`ifdef USER_MGR_ARB_PRIO0_EN
        if (req_i[0]) arb_idx = '0;
`endif
    end

    // A stalled request keeps its index so the A-channel cannot change.
    assign sel = lock_q ? lock_idx_q : arb_idx;

    assign mgr_req_o = !rst_i && ((|req_i) || lock_q)
                     && (cnt_q < CntW'(MaxTrans));
    assign hs  = mgr_req_o && mgr_gnt_i;
    assign pop = mgr_rvalid_i && (cnt_q != '0);

    assign mgr_addr_o  = addr_i[sel];
    assign mgr_we_o    = we_i[sel];
    assign mgr_be_o    = be_i[sel];
    assign mgr_wdata_o = wdata_i[sel];

    assign rdata_o       = mgr_rdata_i;
    assign err_o         = mgr_err_i;
    assign outstanding_o = cnt_q;
    assign unexp_rsp_o   = unexp_q;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int k = 0; k < NumReq; k++) begin
            gnt_o[k]    = hs && (sel == IdxW'(k));
            rvalid_o[k] = pop && (id_q[rd_ptr_q] == IdxW'(k));
        end
    end

    // Pointer after a grant; with fixed priority, index 0 never enters
    // the rotation and a grant to 0 leaves the rotation untouched.
    always_comb begin
        int nxt;
        nxt = int'(sel) + 1;
        if (nxt >= NumReq) nxt = 0;
`ifdef USER_MGR_ARB_PRIO0_EN
        if (sel == '0) nxt = int'(rr_q);
        else if (nxt == 0) nxt = 1;
`endif
        rr_nxt = IdxW'(nxt);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            unexp_q    <= 1'b0;
        end else begin
            if (hs) begin
                rr_q     <= rr_nxt;
                lock_q   <= 1'b0;
                wr_ptr_q <= (wr_ptr_q == PtrW'(MaxTrans - 1))
                          ? '0 : wr_ptr_q + PtrW'(1);
            end else if (mgr_req_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(MaxTrans - 1))
                          ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (hs && !pop)      cnt_q <= cnt_q + CntW'(1);
            else if (!hs && pop) cnt_q <= cnt_q - CntW'(1);
            if (mgr_rvalid_i && cnt_q == '0) unexp_q <= 1'b1;
        end
    end

    // ID storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk_i) begin
        if (hs) id_q[wr_ptr_q] <= sel;
    end

endmodule

// File: doc/user_mgr_arbiter.md
USER_MGR_ARBITER -- requirements
Module: user_mgr_arbiter

Interface
REQ-001 Parameter NumReq, default 2: number of requesters sharing the user manager OBI port (2..8).
REQ-002 Parameter MaxTrans, default 2: maximum outstanding granted transactions (1..4).
REQ-003 Parameter AddrWidth, default 32: address width.
REQ-004 Parameter DataWidth, default 32: data width; byte enable width is DataWidth/8.
REQ-005 clk_i  in  1  single clock; all state samples on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 req_i  in  NumReq  per-requester A-channel request.
REQ-008 addr_i, we_i, be_i, wdata_i  in  NumReq x (AddrWidth, 1, DataWidth/8, DataWidth)  per-requester A-channel payload.
REQ-009 gnt_o  out  NumReq  per-requester grant.
REQ-010 rvalid_o  out  NumReq  per-requester response valid.
REQ-011 rdata_o, err_o  out  DataWidth, 1  response payload, broadcast to all requesters.
REQ-012 mgr_req_o, mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o  out  1, AddrWidth, 1, DataWidth/8, DataWidth  shared manager A-channel.
REQ-013 mgr_gnt_i, mgr_rvalid_i, mgr_rdata_i, mgr_err_i  in  1, 1, DataWidth, 1  shared manager grant and R-channel.
REQ-014 outstanding_o  out  clog2(MaxTrans+1)  count of granted transactions still awaiting a response.
REQ-015 unexp_rsp_o  out  1  sticky flag: mgr_rvalid_i was seen with zero outstanding.

Function
REQ-016 Arbitration is round-robin: the search starts at pointer rr_q and proceeds ascending with wrap; the first index with req_i high is selected.
REQ-017 The handshake is mgr_req_o && mgr_gnt_i; on a handshake to index k, rr_q becomes (k+1) mod NumReq on the next cycle.
REQ-018 When mgr_req_o is high and mgr_gnt_i is low, the selected index is locked in a register and held until the handshake, so the A-channel stays stable even if higher-priority requests arrive.
REQ-019 mgr_req_o = (any req_i high or lock active) && outstanding_q < MaxTrans; the A-channel payload is muxed combinationally from the selected index.
REQ-020 gnt_o[k] = mgr_gnt_i && mgr_req_o && selected==k; all other gnt_o bits are 0.
REQ-021 An ID FIFO of depth MaxTrans stores the requester index on each handshake; responses are in order.
REQ-022 On mgr_rvalid_i with the FIFO non-empty, rvalid_o[head]=1 in the same cycle (zero latency) and the head is popped.
REQ-023 rdata_o=mgr_rdata_i and err_o=mgr_err_i in every cycle.
REQ-024 Simultaneous push and pop: outstanding_q is unchanged and the FIFO order is preserved.
REQ-025 Full: with outstanding_q==MaxTrans, mgr_req_o=0, so no grant is possible; a pop in that cycle re-enables requests from the next cycle.
REQ-026 On mgr_rvalid_i with the FIFO empty: all rvalid_o stay 0, unexp_rsp_o is set and stays set until reset, and the FIFO is unchanged.
REQ-027 A requester that deasserts req_i before a grant is treated as a protocol violation; it is not checked, and the lock holds the index regardless.

Reset
REQ-028 While rst_i is high, rr_q=0, the lock is cleared, the FIFO is empty, outstanding_o=0, unexp_rsp_o=0, mgr_req_o=0, and gnt_o and rvalid_o are all 0.
REQ-029 Reset mid-operation discards the outstanding entries; any later mgr_rvalid_i for them sets unexp_rsp_o.

Configuration
REQ-030 Macro USER_MGR_ARB_PRIO0_EN defined: requester 0 has fixed highest priority whenever req_i[0] is high and the lock is inactive; the remaining requesters use round-robin, and rr_q skips index 0.
REQ-031 Macro USER_MGR_ARB_PRIO0_EN undefined: pure round-robin across all NumReq requesters per REQ-016.

Verification
REQ-032 NumReq=2; req_i=2'b11 held with mgr_gnt_i=1 every cycle -> grants alternate 0,1,0,1; rvalid routes to matching index in grant order.
REQ-033 req_i[1]=1 and mgr_gnt_i=0 for 3 cycles, then req_i[0]=1, then mgr_gnt_i=1 -> gnt_o[1] first; mgr_addr_o is stable across all 4 cycles.
REQ-034 MaxTrans=2; two handshakes with no rvalid -> outstanding_o=2 and mgr_req_o=0; one mgr_rvalid_i -> outstanding_o=1 and mgr_req_o=1 the next cycle.
REQ-035 Full FIFO plus same-cycle rvalid and a pending request -> pop in that cycle, grant in the following cycle, outstanding_o returns to 2.
REQ-036 mgr_rvalid_i pulse after reset with no request -> rvalid_o=0 and unexp_rsp_o=1 until rst_i is asserted.
REQ-037 With USER_MGR_ARB_PRIO0_EN defined: req_i=2'b11 continuously -> only gnt_o[0] for as long as req_i[0] is high.
